// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: the serial-adder state encoding and its default width.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } serial_state_t;

   localparam int SERIAL_ADD_WIDTH = 8;

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full-adder cell; the only carry path in the serial adder.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per operation.
module bit_serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   serial_state_t    state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cout_r;
   logic             cell_s;
   logic             cell_co;

   fa_cell u_cell (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .ci (carry),
      .s  (cell_s),
      .co (cell_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  // Subtract is a + ~b + 1, so the carry flop seeds the +1.
                  a_sr  <= a;
                  b_sr  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               res   <= {cell_s, res[WIDTH-1:1]};
               carry <= cell_co;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cout_r <= cell_co;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign sum  = res;
   assign cout = cout_r;

endmodule
